// File: rtl/io_handshake_responder.sv
// -----------------------------------------------------------------------------
// io_handshake_responder
//
// Peripheral-side responder for the core's INPUT, OUTPUT and PAUSE
// instructions. It conditions the board push-button (two-flop synchronizer,
// debouncer, press/release edge detection). It releases the stalled core with
// a single-cycle confirmation (INPUT/OUTPUT) or continue_button (PAUSE) pulse,
// one per physical press.
//
// Ports:
//   clock           in   system clock
//   reset           in   synchronous, active-high reset
//   is_input        in   core requests INPUT (with is_output: PAUSE)
//   is_output       in   core requests OUTPUT (with is_input: PAUSE)
//   raw_button      in   asynchronous, bouncy, active-high push-button
//   switches        in   board switches, captured on an INPUT press
//   core_data       in   value shown on the display for OUTPUT
//   confirmation    out  one-cycle acknowledge for INPUT/OUTPUT
//   continue_button out  one-cycle acknowledge for PAUSE
//   input_data      out  switches captured at the press, zero-extended
//   display_value   out  last OUTPUT value
//   waiting         out  high while a request waits for a press (LED)
// -----------------------------------------------------------------------------
module io_handshake_responder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SWITCH_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    is_input,
  input  logic                    is_output,
  input  logic                    raw_button,
  input  logic [SWITCH_WIDTH-1:0] switches,
  input  logic [31:0]             core_data,
  output logic                    confirmation,
  output logic                    continue_button,
  output logic [31:0]             input_data,
  output logic [31:0]             display_value,
  output logic                    waiting
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Request classes, encoded directly as {is_output, is_input}.
  localparam logic [1:0] REQ_NONE   = 2'b00;
  localparam logic [1:0] REQ_INPUT  = 2'b01;
  localparam logic [1:0] REQ_OUTPUT = 2'b10;
  localparam logic [1:0] REQ_PAUSE  = 2'b11;

  localparam logic [2:0] S_IDLE               = 3'd0;
  localparam logic [2:0] S_WAIT_RELEASE_FIRST = 3'd1;
  localparam logic [2:0] S_WAIT_PRESS         = 3'd2;
  localparam logic [2:0] S_ACK                = 3'd3;
  localparam logic [2:0] S_HOLD               = 3'd4;

  logic             sync_ff1;
  logic             sync_btn;
  logic             debounced;
  logic             debounced_d;
  logic [CNT_W-1:0] db_count;
  logic             press_event;
  logic             release_event;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [1:0]       req_class;
  logic [1:0]       req_type;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with non-blocking (<=) so every
  // flop samples the pre-edge value of the others; blocking here would collapse
  // the two synchronizer stages into one.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_ff1    <= 1'b0;
      sync_btn    <= 1'b0;
      debounced   <= 1'b0;
      debounced_d <= 1'b0;
      db_count    <= '0;
    end else begin
      sync_ff1    <= raw_button;
      sync_btn    <= sync_ff1;
      debounced_d <= debounced;
      if (sync_btn == debounced) begin
        // Any return to the accepted level restarts the stability window.
        db_count <= '0;
      end else if (db_count == CNT_LAST) begin
        debounced <= sync_btn;
        db_count  <= '0;
      end else begin
        db_count <= db_count + CNT_W'(1);
      end
    end
  end

  assign press_event   =  debounced & ~debounced_d;
  assign release_event = ~debounced &  debounced_d;

  assign req_class = {is_output, is_input};

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default assignment first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        // A button still held from an earlier acknowledge must be released
        // before a press can count for this new request.
        if (req_class != REQ_NONE)
          state_next = debounced ? S_WAIT_RELEASE_FIRST : S_WAIT_PRESS;
      end
      S_WAIT_RELEASE_FIRST: begin
        if (req_class != req_type)
          state_next = S_IDLE;
        else if (release_event)
          state_next = S_WAIT_PRESS;
      end
      S_WAIT_PRESS: begin
        // A dropped or re-typed request abandons this wait without a pulse.
        if (req_class != req_type)
          state_next = S_IDLE;
        else if (press_event)
          state_next = S_ACK;
      end
      S_ACK: begin
        state_next = S_HOLD;
      end
      S_HOLD: begin
        // Strobes are ignored until the button is back up, so one press can
        // never produce a second acknowledge. Testing the level rather than
        // the edge also covers a release that lands during S_ACK.
        if (!debounced)
          state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      req_type      <= REQ_NONE;
      input_data    <= '0;
      display_value <= '0;
    end else begin
      state <= state_next;

      // The request type is frozen when the wait begins; the display is
      // updated at that moment so the user sees the value before pressing.
      if (state == S_IDLE && req_class != REQ_NONE) begin
        req_type <= req_class;
        if (req_class == REQ_OUTPUT)
          display_value <= core_data;
      end

      if (state == S_WAIT_PRESS && req_class == req_type && press_event &&
          req_type == REQ_INPUT)
        input_data <= 32'(switches);
    end
  end

  assign confirmation    = (state == S_ACK) &&
                           (req_type == REQ_INPUT || req_type == REQ_OUTPUT);
  assign continue_button = (state == S_ACK) && (req_type == REQ_PAUSE);
  assign waiting         = (state == S_WAIT_PRESS) ||
                           (state == S_WAIT_RELEASE_FIRST);

endmodule

// File: tb/tb_io_handshake_responder.sv
// -----------------------------------------------------------------------------
// tb_io_handshake_responder
//
// Directed and randomized transactions against io_handshake_responder with
// DEBOUNCE_CYCLES = 4. Expected register contents, pulse counts and the
// raw-edge-to-acknowledge latency (2 sync + 4 debounce + 1 = 7 cycles) come
// from a transaction-level model kept in this bench.
// -----------------------------------------------------------------------------
module tb_io_handshake_responder;

  localparam int DEB     = 4;
  localparam int ACK_LAT = 2 + DEB + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        is_input = 1'b0;
  logic        is_output = 1'b0;
  logic        raw_button = 1'b0;
  logic [15:0] switches = '0;
  logic [31:0] core_data = '0;
  logic        confirmation;
  logic        continue_button;
  logic [31:0] input_data;
  logic [31:0] display_value;
  logic        waiting;

  io_handshake_responder #(
    .DEBOUNCE_CYCLES(DEB),
    .SWITCH_WIDTH   (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .is_input       (is_input),
    .is_output      (is_output),
    .raw_button     (raw_button),
    .switches       (switches),
    .core_data      (core_data),
    .confirmation   (confirmation),
    .continue_button(continue_button),
    .input_data     (input_data),
    .display_value  (display_value),
    .waiting        (waiting)
  );

  always #5 clock = ~clock;

  // Pulse monitor, sampled on the falling edge.
  int cyc       = 0;
  int n_conf    = 0;
  int n_cont    = 0;
  int n_both    = 0;
  int n_long    = 0;
  int pulse_cyc = -1000;
  logic prev_conf = 1'b0;
  logic prev_cont = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (confirmation)    n_conf <= n_conf + 1;
    if (continue_button) n_cont <= n_cont + 1;
    if (confirmation && continue_button) n_both <= n_both + 1;
    if ((confirmation && prev_conf) || (continue_button && prev_cont))
      n_long <= n_long + 1;
    if (confirmation || continue_button) pulse_cyc <= cyc;
    prev_conf <= confirmation;
    prev_cont <= continue_button;
  end

  // Reference model state.
  logic [31:0] exp_input_data = '0;
  logic [31:0] exp_display    = '0;
  int base_conf;
  int base_cont;
  int rise_cyc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic snap();
    base_conf = n_conf;
    base_cont = n_cont;
  endtask

  task automatic check_pulses(input string tag, input int exp_conf,
                              input int exp_cont);
    check({tag, "_conf_count"}, 32'(n_conf - base_conf), 32'(exp_conf));
    check({tag, "_cont_count"}, 32'(n_cont - base_cont), 32'(exp_cont));
  endtask

  // Optional bounce (toggle every 2 cycles for 12 cycles), then a clean
  // rising edge whose cycle is recorded for the latency check.
  task automatic press(input bit bounce);
    if (bounce) begin
      for (int i = 0; i < 6; i++) begin
        raw_button = (i % 2 == 0);
        cycles(2);
      end
    end
    raw_button = 1'b1;
    rise_cyc   = cyc;
  endtask

  task automatic release_btn();
    raw_button = 1'b0;
    cycles(12);
  endtask

  // kind: 1 = INPUT, 2 = OUTPUT, 3 = PAUSE. Strobes stay high through the hold.
  task automatic transact(input string tag, input logic [1:0] kind,
                          input logic [15:0] sw, input logic [31:0] data,
                          input bit bounce, input int hold);
    snap();
    switches  = sw;
    core_data = data;
    {is_output, is_input} = kind;
    cycles(1);
    if (kind == 2'd2) exp_display = data;
    check({tag, "_waiting"}, 32'(waiting), 32'd1);
    check({tag, "_display_early"}, display_value, exp_display);
    press(bounce);
    cycles(hold);
    if (kind == 2'd1) exp_input_data = {16'h0000, sw};
    check_pulses(tag, (kind == 2'd3) ? 0 : 1, (kind == 2'd3) ? 1 : 0);
    check({tag, "_latency"}, 32'(pulse_cyc - rise_cyc), 32'(ACK_LAT));
    check({tag, "_input_data"}, input_data, exp_input_data);
    check({tag, "_display"}, display_value, exp_display);
    {is_output, is_input} = 2'b00;
    cycles(1);
    release_btn();
    check({tag, "_idle_waiting"}, 32'(waiting), 32'd0);
    check_pulses({tag, "_after"}, (kind == 2'd3) ? 0 : 1, (kind == 2'd3) ? 1 : 0);
  endtask

  initial begin
    // Reset state.
    cycles(3);
    check("rst_conf", 32'(confirmation), 32'd0);
    check("rst_cont", 32'(continue_button), 32'd0);
    check("rst_input_data", input_data, 32'd0);
    check("rst_display", display_value, 32'd0);
    check("rst_waiting", 32'(waiting), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Basic INPUT, OUTPUT (long hold), PAUSE.
    transact("input",  2'd1, 16'hA5A5, 32'h0,        1'b0, 10);
    transact("output", 2'd2, 16'h0,    32'hDEADBEEF, 1'b0, 20);
    transact("pause",  2'd3, 16'hFFFF, 32'h12345678, 1'b0, 10);

    // Bounce before a stable press.
    transact("bounce", 2'd1, 16'h3C3C, 32'h0, 1'b1, 10);

    // Button held through an ACK while the core immediately re-requests.
    snap();
    switches = 16'h1111;
    is_input = 1'b1;
    press(1'b0);
    cycles(10);
    exp_input_data = 32'h00001111;
    check_pulses("held_first", 1, 0);
    is_input = 1'b0;
    cycles(1);
    switches = 16'h1234;
    is_input = 1'b1;
    cycles(10);
    check_pulses("held_still", 1, 0);
    release_btn();
    check("held_wait", 32'(waiting), 32'd1);
    check_pulses("held_released", 1, 0);
    press(1'b0);
    cycles(10);
    exp_input_data = 32'h00001234;
    check_pulses("held_fresh", 2, 0);
    check("held_latency", 32'(pulse_cyc - rise_cyc), 32'(ACK_LAT));
    check("held_input_data", input_data, exp_input_data);
    is_input = 1'b0;
    cycles(1);
    release_btn();

    // Button already down before the request appears.
    snap();
    raw_button = 1'b1;
    cycles(10);
    switches = 16'h0F0F;
    is_input = 1'b1;
    cycles(1);
    check("pre_waiting", 32'(waiting), 32'd1);
    cycles(10);
    check_pulses("pre_held", 0, 0);
    release_btn();
    press(1'b0);
    cycles(10);
    exp_input_data = 32'h00000F0F;
    check_pulses("pre_fresh", 1, 0);
    check("pre_latency", 32'(pulse_cyc - rise_cyc), 32'(ACK_LAT));
    check("pre_input_data", input_data, exp_input_data);
    is_input = 1'b0;
    cycles(1);
    release_btn();

    // Request dropped while waiting: no pulse.
    snap();
    is_output = 1'b1;
    core_data = 32'hCAFEF00D;
    exp_display = 32'hCAFEF00D;
    cycles(3);
    is_output = 1'b0;
    cycles(2);
    check("drop_waiting", 32'(waiting), 32'd0);
    press(1'b0);
    cycles(10);
    check_pulses("drop", 0, 0);
    check("drop_display", display_value, exp_display);
    release_btn();

    // Reset while waiting for a press.
    is_input = 1'b1;
    cycles(3);
    check("mid_waiting", 32'(waiting), 32'd1);
    reset = 1'b1;
    cycles(1);
    exp_input_data = '0;
    exp_display    = '0;
    check("mid_rst_waiting", 32'(waiting), 32'd0);
    check("mid_rst_input_data", input_data, exp_input_data);
    check("mid_rst_display", display_value, exp_display);
    reset    = 1'b0;
    is_input = 1'b0;
    cycles(2);
    transact("post_rst", 2'd1, 16'h5A5A, 32'h0, 1'b0, 10);

    // Randomized transactions.
    for (int i = 0; i < 10; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(1, 3));
      transact($sformatf("rand%0d", i), kind, 16'($urandom), $urandom,
               1'($urandom_range(0, 1)), 8 + $urandom_range(0, 12));
      cycles($urandom_range(1, 5));
    end

    check("never_both", 32'(n_both), 32'd0);
    check("never_long", 32'(n_long), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
